// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: state encoding, op-field layout,
// fetch op code and the default start of the I/O-mapped region.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY_LSB = 2'd1,
    ST_BUSY_IF  = 2'd2,
    ST_GAP      = 2'd3
  } arb_state_e;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;
  localparam int          OP_STORE_BIT    = 3;
  localparam logic [3:0]  OP_FETCH        = 4'b0010;

  // Stores into the I/O region are the only requests subject to back-pressure.
  function automatic logic is_io_store(input logic [3:0]  op,
                                       input logic [31:0] addr,
                                       input logic [31:0] io_base);
    return op[OP_STORE_BIT] && (addr >= io_base);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester (LSB / instruction fetch) and memory-controller signals of the arbiter.
// slave = arbiter side, master = requesters plus memory controller.
interface mem_arbiter_if;

  logic        lsb_req;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_data;
  logic [3:0]  lsb_op;
  logic        lsb_done;
  logic [31:0] lsb_rdata;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_inst;

  logic        mc_valid;
  logic [31:0] mc_addr;
  logic [31:0] mc_data;
  logic [3:0]  mc_op;
  logic        mc_fetch;
  logic        mc_done;
  logic [31:0] mc_rdata;

  modport slave (
    input  lsb_req, lsb_addr, lsb_data, lsb_op, if_req, if_addr, mc_done, mc_rdata,
    output lsb_done, lsb_rdata, if_done, if_inst,
           mc_valid, mc_addr, mc_data, mc_op, mc_fetch
  );

  modport master (
    output lsb_req, lsb_addr, lsb_data, lsb_op, if_req, if_addr, mc_done, mc_rdata,
    input  lsb_done, lsb_rdata, if_done, if_inst,
           mc_valid, mc_addr, mc_data, mc_op, mc_fetch
  );

endinterface

// File: rtl/mem_arbiter_starve_cnt.sv
// Saturating count of consecutive LSB grants made while a fetch was waiting.
// Clear has priority over increment; o_sat flags the limit.
module mem_arbiter_starve_cnt #(
  parameter int LIMIT = 4,
  parameter int W     = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1)
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  logic [W-1:0] r_cnt;

  assign o_sat = (r_cnt == W'(LIMIT));

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !o_sat) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: LSB normally wins, instruction fetch wins once
// starved; one transaction in flight, followed by a one-cycle gap.
//
// state       | meaning
// ST_IDLE     | arbitrate between eligible LSB request and fetch request
// ST_BUSY_LSB | LSB transaction presented to the memory controller
// ST_BUSY_IF  | fetch presented to the memory controller (may be flagged drop)
// ST_GAP      | done pulse visible, no grant, back to idle next cycle
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int          STARVE_LIMIT = 4,
  parameter logic [31:0] IO_BASE      = IO_BASE_DEFAULT
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic         flush_in,
  input  logic         io_buffer_full,
  mem_arbiter_if.slave bus
);

  arb_state_e  r_state,     w_state_nxt;
  logic        r_mc_valid,  w_mc_valid_nxt;
  logic [31:0] r_mc_addr,   w_mc_addr_nxt;
  logic [31:0] r_mc_data,   w_mc_data_nxt;
  logic [3:0]  r_mc_op,     w_mc_op_nxt;
  logic        r_mc_fetch,  w_mc_fetch_nxt;
  logic        r_lsb_done,  w_lsb_done_nxt;
  logic [31:0] r_lsb_rdata, w_lsb_rdata_nxt;
  logic        r_if_done,   w_if_done_nxt;
  logic [31:0] r_if_inst,   w_if_inst_nxt;
  logic        r_drop,      w_drop_nxt;

  logic w_idle;
  logic w_lsb_elig;
  logic w_if_elig;
  logic w_starved;
  logic w_grant_if;
  logic w_grant_lsb;
  logic w_cnt_inc;
  logic w_cnt_clr;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_lsb_elig  = bus.lsb_req &&
                       !(is_io_store(bus.lsb_op, bus.lsb_addr, IO_BASE) && io_buffer_full);
  assign w_if_elig   = bus.if_req && !flush_in;
  assign w_grant_if  = w_idle && w_if_elig && (!w_lsb_elig || w_starved);
  assign w_grant_lsb = w_idle && w_lsb_elig && !w_grant_if;

  // Counter updates are pre-gated by rdy_in so it freezes with the rest of the state.
  assign w_cnt_inc = rdy_in && w_grant_lsb && bus.if_req;
  assign w_cnt_clr = rdy_in && w_idle && (w_grant_if || !bus.if_req);

  mem_arbiter_starve_cnt #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .i_inc  (w_cnt_inc),
    .i_clr  (w_cnt_clr),
    .o_sat  (w_starved)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_mc_valid_nxt  = r_mc_valid;
    w_mc_addr_nxt   = r_mc_addr;
    w_mc_data_nxt   = r_mc_data;
    w_mc_op_nxt     = r_mc_op;
    w_mc_fetch_nxt  = r_mc_fetch;
    w_lsb_done_nxt  = 1'b0;
    w_lsb_rdata_nxt = r_lsb_rdata;
    w_if_done_nxt   = 1'b0;
    w_if_inst_nxt   = r_if_inst;
    w_drop_nxt      = r_drop;

    case (r_state)
      ST_IDLE: begin
        if (w_grant_if) begin
          w_state_nxt    = ST_BUSY_IF;
          w_mc_valid_nxt = 1'b1;
          w_mc_addr_nxt  = bus.if_addr;
          w_mc_data_nxt  = '0;
          w_mc_op_nxt    = OP_FETCH;
          w_mc_fetch_nxt = 1'b1;
        end else if (w_grant_lsb) begin
          w_state_nxt    = ST_BUSY_LSB;
          w_mc_valid_nxt = 1'b1;
          w_mc_addr_nxt  = bus.lsb_addr;
          w_mc_data_nxt  = bus.lsb_data;
          w_mc_op_nxt    = bus.lsb_op;
          w_mc_fetch_nxt = 1'b0;
        end
      end
      ST_BUSY_LSB: begin
        if (bus.mc_done) begin
          w_state_nxt     = ST_GAP;
          w_mc_valid_nxt  = 1'b0;
          w_lsb_done_nxt  = 1'b1;
          w_lsb_rdata_nxt = bus.mc_rdata;
        end
      end
      ST_BUSY_IF: begin
        if (flush_in) begin
          w_drop_nxt = 1'b1;
        end
        if (bus.mc_done) begin
          w_state_nxt    = ST_GAP;
          w_mc_valid_nxt = 1'b0;
          w_drop_nxt     = 1'b0;
          // A flush arriving on the completion cycle still kills the fetch.
          if (!(r_drop || flush_in)) begin
            w_if_done_nxt = 1'b1;
            w_if_inst_nxt = bus.mc_rdata;
          end
        end
      end
      ST_GAP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state     <= ST_IDLE;
      r_mc_valid  <= 1'b0;
      r_mc_addr   <= '0;
      r_mc_data   <= '0;
      r_mc_op     <= '0;
      r_mc_fetch  <= 1'b0;
      r_lsb_done  <= 1'b0;
      r_lsb_rdata <= '0;
      r_if_done   <= 1'b0;
      r_if_inst   <= '0;
      r_drop      <= 1'b0;
    end else if (rdy_in) begin
      r_state     <= w_state_nxt;
      r_mc_valid  <= w_mc_valid_nxt;
      r_mc_addr   <= w_mc_addr_nxt;
      r_mc_data   <= w_mc_data_nxt;
      r_mc_op     <= w_mc_op_nxt;
      r_mc_fetch  <= w_mc_fetch_nxt;
      r_lsb_done  <= w_lsb_done_nxt;
      r_lsb_rdata <= w_lsb_rdata_nxt;
      r_if_done   <= w_if_done_nxt;
      r_if_inst   <= w_if_inst_nxt;
      r_drop      <= w_drop_nxt;
    end
  end

  assign bus.mc_valid  = r_mc_valid;
  assign bus.mc_addr   = r_mc_addr;
  assign bus.mc_data   = r_mc_data;
  assign bus.mc_op     = r_mc_op;
  assign bus.mc_fetch  = r_mc_fetch;
  assign bus.lsb_done  = r_lsb_done;
  assign bus.lsb_rdata = r_lsb_rdata;
  assign bus.if_done   = r_if_done;
  assign bus.if_inst   = r_if_inst;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed corner cases, then randomized transactions
// checked against a transaction-level arbitration model.
module tb_mem_arbiter;

  localparam int          LIMIT = 4;
  localparam logic [31:0] IOB   = 32'h0003_0000;
  localparam logic [3:0]  FOP   = 4'b0010;

  logic clk_in         = 1'b0;
  logic rst_in         = 1'b0;
  logic rdy_in         = 1'b1;
  logic flush_in       = 1'b0;
  logic io_buffer_full = 1'b0;

  mem_arbiter_if bus();

  mem_arbiter #(
    .STARVE_LIMIT (LIMIT),
    .IO_BASE      (IOB)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .flush_in       (flush_in),
    .io_buffer_full (io_buffer_full),
    .bus            (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          m_starve;
  logic [31:0] m_lsb_rdata;
  logic [31:0] m_if_inst;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    bus.lsb_req  = 1'b0;
    bus.lsb_addr = '0;
    bus.lsb_data = '0;
    bus.lsb_op   = '0;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.mc_done  = 1'b0;
    bus.mc_rdata = '0;
    flush_in       = 1'b0;
    io_buffer_full = 1'b0;
    rdy_in         = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_in = 1'b0;
    step();
    step();
    rst_in      = 1'b1;
    m_starve    = 0;
    m_lsb_rdata = '0;
    m_if_inst   = '0;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, ".mc_valid"}, bus.mc_valid, 0);
    check_eq({tag, ".lsb_done"}, bus.lsb_done, 0);
    check_eq({tag, ".if_done"},  bus.if_done,  0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".mc_valid"},  bus.mc_valid,  0);
    check_eq({tag, ".mc_addr"},   bus.mc_addr,   0);
    check_eq({tag, ".mc_data"},   bus.mc_data,   0);
    check_eq({tag, ".mc_op"},     bus.mc_op,     0);
    check_eq({tag, ".mc_fetch"},  bus.mc_fetch,  0);
    check_eq({tag, ".lsb_done"},  bus.lsb_done,  0);
    check_eq({tag, ".lsb_rdata"}, bus.lsb_rdata, 0);
    check_eq({tag, ".if_done"},   bus.if_done,   0);
    check_eq({tag, ".if_inst"},   bus.if_inst,   0);
  endtask

  task automatic check_grant(input string tag, input logic fetch, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] op);
    check_eq({tag, ".mc_valid"}, bus.mc_valid, 1);
    check_eq({tag, ".mc_fetch"}, bus.mc_fetch, fetch);
    check_eq({tag, ".mc_addr"},  bus.mc_addr,  addr);
    check_eq({tag, ".mc_data"},  bus.mc_data,  data);
    check_eq({tag, ".mc_op"},    bus.mc_op,    op);
  endtask

  // Completes the outstanding transaction immediately, then walks through the gap.
  task automatic serve(input string tag, input logic [31:0] rd, input bit exp_lsb, input bit exp_if);
    bus.mc_done  = 1'b1;
    bus.mc_rdata = rd;
    step();
    bus.mc_done = 1'b0;
    check_eq({tag, ".lsb_done"}, bus.lsb_done, exp_lsb);
    check_eq({tag, ".if_done"},  bus.if_done,  exp_if);
    check_eq({tag, ".mc_valid"}, bus.mc_valid, 0);
    if (exp_lsb) check_eq({tag, ".lsb_rdata"}, bus.lsb_rdata, rd);
    if (exp_if)  check_eq({tag, ".if_inst"},   bus.if_inst,   rd);
    step();
    check_quiet({tag, ".gap"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          lsb_pend;
    bit          if_pend;
    bit          lsb_ok;
    bit          if_ok;
    bit          drop;
    int          win;
    int          n_wait;
    logic [31:0] l_addr;
    logic [31:0] l_data;
    logic [3:0]  l_op;
    logic [31:0] i_addr;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic [3:0]  e_op;
    logic [31:0] rd;

    idle_inputs();
    do_reset();
    check_all_zero("reset");

    // LSB beats a simultaneous fetch; fetch follows after the gap.
    do_reset();
    bus.lsb_req = 1'b1; bus.lsb_addr = 32'h100; bus.lsb_data = 32'h0; bus.lsb_op = 4'b0010;
    bus.if_req  = 1'b1; bus.if_addr  = 32'h0;
    step();
    check_grant("simul.lsb", 1'b0, 32'h100, 32'h0, 4'b0010);
    serve("simul.lsb_done", 32'hCAFE_0001, 1'b1, 1'b0);
    bus.lsb_req = 1'b0;
    step();
    check_grant("simul.fetch", 1'b1, 32'h0, 32'h0, FOP);
    serve("simul.if_done", 32'h0000_0013, 1'b0, 1'b1);

    // Continuous LSB traffic: fetch must win the fifth arbitration.
    do_reset();
    bus.lsb_req = 1'b1; bus.lsb_addr = 32'h200; bus.lsb_data = 32'h0; bus.lsb_op = 4'b0010;
    bus.if_req  = 1'b1; bus.if_addr  = 32'h44;
    for (int a = 1; a <= 5; a++) begin
      step();
      check_eq($sformatf("starve.arb%0d.fetch", a), bus.mc_fetch, (a == 5));
      serve($sformatf("starve.arb%0d", a), 32'h1000 + a, (a != 5), (a == 5));
    end
    step();
    check_eq("starve.after_clear.fetch", bus.mc_fetch, 0);

    // I/O store held by back-pressure while a fetch proceeds.
    do_reset();
    bus.lsb_req = 1'b1; bus.lsb_addr = 32'h0003_0000; bus.lsb_data = 32'h1234_5678; bus.lsb_op = 4'b1010;
    io_buffer_full = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    step();
    check_grant("io.fetch_first", 1'b1, 32'h40, 32'h0, FOP);
    bus.if_req = 1'b0;
    serve("io.fetch_done", 32'h0000_0093, 1'b0, 1'b1);
    step();
    check_eq("io.store_held", bus.mc_valid, 0);
    io_buffer_full = 1'b0;
    step();
    check_grant("io.store_go", 1'b0, 32'h0003_0000, 32'h1234_5678, 4'b1010);
    serve("io.store_done", 32'h0, 1'b1, 1'b0);
    bus.lsb_addr = 32'h0002_FFFF;
    io_buffer_full = 1'b1;
    step();
    check_grant("io.below_base", 1'b0, 32'h0002_FFFF, 32'h1234_5678, 4'b1010);
    serve("io.below_done", 32'h0, 1'b1, 1'b0);

    // Flush: suppresses an idle fetch grant, then drops a fetch in flight.
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h80;
    flush_in = 1'b1;
    step();
    check_eq("flush.idle_suppress", bus.mc_valid, 0);
    flush_in = 1'b0;
    step();
    check_grant("flush.fetch", 1'b1, 32'h80, 32'h0, FOP);
    bus.if_req = 1'b0;
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    step();
    step();
    check_eq("flush.still_busy", bus.mc_valid, 1);
    bus.mc_done = 1'b1; bus.mc_rdata = 32'hDEAD_BEEF;
    step();
    bus.mc_done = 1'b0;
    check_eq("flush.if_done", bus.if_done, 0);
    check_eq("flush.if_inst", bus.if_inst, 0);
    check_eq("flush.mc_valid", bus.mc_valid, 0);
    step();
    check_quiet("flush.gap");
    bus.if_req = 1'b1; bus.if_addr = 32'h84;
    step();
    check_grant("flush.refetch", 1'b1, 32'h84, 32'h0, FOP);
    bus.if_req = 1'b0;
    serve("flush.refetch_done", 32'h0000_0067, 1'b0, 1'b1);
    bus.lsb_req = 1'b1; bus.lsb_addr = 32'h300; bus.lsb_data = 32'h55; bus.lsb_op = 4'b1001;
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    check_grant("flush.lsb_unaffected", 1'b0, 32'h300, 32'h55, 4'b1001);

    // rdy_in low on the completion cycle defers the done pulse.
    do_reset();
    bus.lsb_req = 1'b1; bus.lsb_addr = 32'h140; bus.lsb_op = 4'b0010;
    step();
    bus.lsb_req = 1'b0;
    check_eq("rdy.granted", bus.mc_valid, 1);
    bus.mc_done = 1'b1; bus.mc_rdata = 32'hA5A5_0001;
    rdy_in = 1'b0;
    step();
    check_eq("rdy.frozen1.lsb_done", bus.lsb_done, 0);
    check_eq("rdy.frozen1.mc_valid", bus.mc_valid, 1);
    step();
    check_eq("rdy.frozen2.lsb_done", bus.lsb_done, 0);
    rdy_in = 1'b1;
    step();
    bus.mc_done = 1'b0;
    check_eq("rdy.done", bus.lsb_done, 1);
    check_eq("rdy.rdata", bus.lsb_rdata, 32'hA5A5_0001);
    rdy_in = 1'b0;
    step();
    check_eq("rdy.done_held", bus.lsb_done, 1);
    rdy_in = 1'b1;
    step();
    check_eq("rdy.done_cleared", bus.lsb_done, 0);
    step();
    check_quiet("rdy.after");

    // Reset in the middle of an LSB transaction, overriding rdy_in.
    do_reset();
    bus.lsb_req = 1'b1; bus.lsb_addr = 32'h100; bus.lsb_data = 32'h77; bus.lsb_op = 4'b1010;
    step();
    check_eq("rstmid.granted", bus.mc_valid, 1);
    bus.lsb_req = 1'b0;
    rst_in = 1'b0; rdy_in = 1'b0;
    bus.mc_done = 1'b1; bus.mc_rdata = 32'h1111_2222;
    step(); step(); step();
    check_all_zero("rstmid");
    rst_in = 1'b1; rdy_in = 1'b1; bus.mc_done = 1'b0;
    step();
    check_quiet("rstmid.after1");
    step();
    check_quiet("rstmid.after2");

    // Stray mc_done while idle is ignored.
    do_reset();
    bus.mc_done = 1'b1; bus.mc_rdata = 32'h9999_9999;
    step();
    bus.mc_done = 1'b0;
    check_quiet("stray_done");
    check_eq("stray_done.lsb_rdata", bus.lsb_rdata, 0);

    // Randomized transactions against the arbitration model.
    do_reset();
    lsb_pend = 1'b0;
    if_pend  = 1'b0;
    l_addr = '0; l_data = '0; l_op = '0; i_addr = '0;
    for (int it = 0; it < 300; it++) begin
      if (!lsb_pend && $urandom_range(0, 2) != 0) begin
        lsb_pend = 1'b1;
        l_op     = 4'($urandom_range(0, 15));
        l_addr   = ($urandom_range(0, 3) == 0) ? IOB + ($urandom & 32'hFF) : ($urandom & 32'h0002_FFFF);
        l_data   = $urandom;
      end
      if (!if_pend && $urandom_range(0, 2) != 0) begin
        if_pend = 1'b1;
        i_addr  = $urandom & 32'h0002_FFFC;
      end
      bus.lsb_req = lsb_pend; bus.lsb_addr = l_addr; bus.lsb_data = l_data; bus.lsb_op = l_op;
      bus.if_req  = if_pend;  bus.if_addr  = i_addr;
      io_buffer_full = ($urandom_range(0, 2) == 0);
      flush_in       = ($urandom_range(0, 4) == 0);
      rdy_in         = 1'b1;

      lsb_ok = lsb_pend && !(l_op[3] && (l_addr >= IOB) && io_buffer_full);
      if_ok  = if_pend && !flush_in;
      if (if_ok && (!lsb_ok || m_starve == LIMIT)) win = 2;
      else if (lsb_ok)                             win = 1;
      else                                         win = 0;
      if (win == 2 || !if_pend)                    m_starve = 0;
      else if (win == 1 && m_starve < LIMIT)       m_starve++;

      step();
      flush_in = 1'b0;
      if (win == 0) begin
        check_eq("rnd.no_grant", bus.mc_valid, 0);
        continue;
      end
      e_addr = (win == 2) ? i_addr : l_addr;
      e_data = (win == 2) ? 32'h0 : l_data;
      e_op   = (win == 2) ? FOP : l_op;
      check_grant($sformatf("rnd%0d.grant", it), (win == 2), e_addr, e_data, e_op);

      drop   = 1'b0;
      n_wait = $urandom_range(0, 3);
      for (int k = 0; k < n_wait; k++) begin
        rdy_in   = ($urandom_range(0, 3) != 0);
        flush_in = ($urandom_range(0, 3) == 0);
        step();
        if (win == 2 && flush_in && rdy_in) drop = 1'b1;
        check_eq("rnd.busy.mc_valid", bus.mc_valid, 1);
        check_eq("rnd.busy.mc_addr",  bus.mc_addr,  e_addr);
      end

      rd = $urandom;
      bus.mc_done = 1'b1; bus.mc_rdata = rd;
      for (int t = 0; t < 5; t++) begin
        rdy_in   = (t == 4) ? 1'b1 : ($urandom_range(0, 3) != 0);
        flush_in = ($urandom_range(0, 3) == 0);
        step();
        if (win == 2 && flush_in && rdy_in) drop = 1'b1;
        if (rdy_in) break;
        check_eq("rnd.stall.lsb_done", bus.lsb_done, 0);
        check_eq("rnd.stall.if_done",  bus.if_done,  0);
        check_eq("rnd.stall.mc_valid", bus.mc_valid, 1);
      end
      bus.mc_done = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;

      if (win == 1)          m_lsb_rdata = rd;
      if (win == 2 && !drop) m_if_inst   = rd;
      check_eq($sformatf("rnd%0d.lsb_done", it), bus.lsb_done, (win == 1));
      check_eq($sformatf("rnd%0d.if_done", it),  bus.if_done,  (win == 2 && !drop));
      check_eq("rnd.lsb_rdata", bus.lsb_rdata, m_lsb_rdata);
      check_eq("rnd.if_inst",   bus.if_inst,   m_if_inst);
      check_eq("rnd.done.mc_valid", bus.mc_valid, 0);
      step();
      check_quiet("rnd.gap");
      if (win == 1) lsb_pend = 1'b0;
      else          if_pend  = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, the maximum number of consecutive LSB grants while a fetch is waiting.
REQ-002 The block SHALL have parameter IO_BASE, default 32'h0003_0000, the lowest I/O-mapped address.
REQ-003 It SHALL have ports clk_in, input, 1, the single system clock.
REQ-004 It SHALL have rst_in, input, 1, synchronous active-low reset.
REQ-005 It SHALL have rdy_in, input, 1, global ready; state frozen while low.
REQ-006 It SHALL have lsb_req, input, 1; lsb_addr, input, 32; lsb_data, input, 32; lsb_op, input, 4 ([1:0] width 0/1/2, [2] unsigned, [3] store).
REQ-007 It SHALL have lsb_done, output, 1, one-cycle completion pulse; lsb_rdata, output, 32, load result valid with lsb_done.
REQ-008 It SHALL have if_req, input, 1; if_addr, input, 32; if_done, output, 1, pulse; if_inst, output, 32, valid with if_done.
REQ-009 It SHALL have flush_in, input, 1, discard any fetch in progress.
REQ-010 It SHALL have io_buffer_full, input, 1, I/O store back-pressure.
REQ-011 It SHALL have mc_valid, output, 1; mc_addr, output, 32; mc_data, output, 32; mc_op, output, 4; mc_fetch, output, 1 (1 = instruction fetch).
REQ-012 It SHALL have mc_done, input, 1, memory-controller completion pulse; mc_rdata, input, 32, data valid with mc_done.

Function
REQ-013 States SHALL be IDLE, BUSY_LSB, BUSY_IF, GAP.
REQ-014 In IDLE, an eligible lsb_req SHALL win over if_req, unless the starvation counter equals STARVE_LIMIT and if_req is high; then the fetch SHALL win.
REQ-015 An LSB request SHALL be ineligible while lsb_op[3]=1, lsb_addr>=IO_BASE and io_buffer_full=1; if_req may be granted meanwhile.
REQ-016 On grant, the request SHALL be latched and mc_valid/mc_addr/mc_data/mc_op/mc_fetch driven from the next cycle, held constant until mc_done.
REQ-017 For a fetch, mc_op SHALL be 4'b0010 and mc_data 0.
REQ-018 Starvation counter: increment on LSB grant while if_req=1, saturate at STARVE_LIMIT, clear on fetch grant or when if_req=0 in IDLE.
REQ-019 In BUSY_* on mc_done: deassert mc_valid and go to GAP; in the same edge register lsb_done=1 with lsb_rdata=mc_rdata, or if_done=1 with if_inst=mc_rdata.
REQ-020 GAP SHALL last exactly one cycle, clear done pulses and return to IDLE; no grant in GAP.
REQ-021 Minimum requester latency: request seen in IDLE at cycle N, mc_valid at N+1, done pulse the cycle after mc_done.
REQ-022 flush_in in BUSY_IF SHALL set a drop flag; the fetch SHALL still complete downstream but if_done SHALL stay 0.
REQ-023 flush_in in IDLE SHALL suppress fetch grant that cycle; LSB transactions SHALL be unaffected by flush_in.
REQ-024 mc_done outside BUSY_* SHALL be ignored.
REQ-025 While rdy_in=0 all registers SHALL hold, including done pulses.
REQ-026 lsb_done and if_done SHALL never be high in the same cycle.

Reset
REQ-027 On rising clk_in with rst_in=0: state IDLE, mc_valid=0, mc_addr/mc_data/mc_op=0, mc_fetch=0, lsb_done=if_done=0, lsb_rdata=if_inst=0, counter=0, drop flag=0.
REQ-028 Reset mid-transaction SHALL abandon it without any done pulse; reset SHALL override rdy_in.

Structure
REQ-029 State encodings, op-field bit positions, fetch op code and IO_BASE default SHALL live in the shared const.v include.
REQ-030 A sub-module arb_starve_cnt (saturating counter with inc/clr) is natural; everything else is a single always block.

Verification
REQ-031 Reset: rst_in=0 for 3 cycles during BUSY_LSB -> all outputs 0, state IDLE, no done pulse.
REQ-032 Simultaneous lsb_req (load, addr 0x100) and if_req (0x0) -> LSB granted first, mc_addr=0x100, mc_fetch=0; fetch granted after GAP.
REQ-033 if_req held with continuous lsb_req, STARVE_LIMIT=4 -> fetch granted on 5th arbitration.
REQ-034 Store to 0x30000 with io_buffer_full=1, if_req high -> fetch served, store held; io_buffer_full drops -> store granted.
REQ-035 flush_in in BUSY_IF, mc_done 3 cycles later with mc_rdata=0xDEADBEEF -> if_done stays 0, GAP then IDLE.
REQ-036 rdy_in=0 on the mc_done cycle -> completion deferred, lsb_done fires exactly once after rdy_in returns.
